// File: rtl/store_lane_packer_pkg.sv
// Shared store-path types: size encodings, byte-enable constants and the buffered entry format.
package mips_mem_pkg;

  localparam int unsigned MemAddrW = 32;
  localparam int unsigned MemDataW = 32;
  localparam int unsigned MemBeW   = MemDataW / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [MemBeW-1:0] BE_ALL     = 4'b1111;
  localparam logic [MemBeW-1:0] BE_LO_HALF = 4'b0011;
  localparam logic [MemBeW-1:0] BE_HI_HALF = 4'b1100;

  typedef struct packed {
    logic [MemAddrW-1:0] addr;
    logic [MemDataW-1:0] wdata;
    logic [MemBeW-1:0]   be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_packer_if.sv
// Store request / memory write bundle; slave is the packer's view, master the driver's view.
interface store_lane_packer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_WIDTH-1:0]   in_addr;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [1:0]              in_size;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_WIDTH-1:0]   out_addr;
  logic [DATA_WIDTH-1:0]   out_wdata;
  logic [DATA_WIDTH/8-1:0] out_be;
  logic [CntW-1:0]         count;
  logic                    misalign_err;
  logic [ADDR_WIDTH-1:0]   bad_addr;

  modport master (
    output flush, in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_wdata, out_be, count, misalign_err, bad_addr
  );

  modport slave (
    input  flush, in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_wdata, out_be, count, misalign_err, bad_addr
  );
endinterface

// File: rtl/store_lane_packer_pack.sv
// Combinational lane packing: replicates store data across lanes and derives byte enables.
module store_lane_pack
  import mips_mem_pkg::*;
(
  input  logic [1:0]          addr_lo,
  input  logic [MemDataW-1:0] data,
  input  size_e               size,
  output logic [MemDataW-1:0] wdata,
  output logic [MemBeW-1:0]   be,
  output logic                misaligned
);

  always_comb begin
    wdata      = data;
    be         = BE_ALL;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
        misaligned = addr_lo[0];
      end
      // Reserved size behaves as a word store.
      SZ_WORD, SZ_RSVD: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/store_lane_packer.sv
// Store buffer between MEM stage and data-memory write port; FIFO of packed writes.
// Optional misaligned-store trap enabled by defining MISALIGN_TRAP_EN.
module store_lane_packer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MemDataW,
  parameter int unsigned ADDR_WIDTH = MemAddrW,
  parameter int unsigned DEPTH      = 2
) (
  input logic               clk,
  input logic               rst_n,
  store_lane_packer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  store_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] bad_addr_q;

  logic [DATA_WIDTH-1:0] pack_wdata;
  logic [MemBeW-1:0]     pack_be;
  logic                  pack_misaligned;
  logic                  accept, push, pop, out_valid;
  store_entry_t          entry_in;

  store_lane_pack u_pack (
    .addr_lo    (bus.in_addr[1:0]),
    .data       (bus.in_data),
    .size       (size_e'(bus.in_size)),
    .wdata      (pack_wdata),
    .be         (pack_be),
    .misaligned (pack_misaligned)
  );

  assign out_valid   = (count_q != '0);
  assign bus.in_ready = (count_q < CntW'(DEPTH)) && !bus.flush;
  assign accept      = bus.in_valid && bus.in_ready;
  assign pop         = out_valid && bus.out_ready;

`ifdef MISALIGN_TRAP_EN
  // Misaligned stores complete the handshake but never reach memory.
  assign push = accept && !pack_misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = pack_misaligned;
  assign push = accept;
`endif

  assign entry_in = '{addr: {bus.in_addr[ADDR_WIDTH-1:2], 2'b00}, wdata: pack_wdata, be: pack_be};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= entry_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      err_q <= accept && pack_misaligned;
      if (accept && pack_misaligned) bad_addr_q <= bus.in_addr;
    end
  end
`else
  assign err_q      = 1'b0;
  assign bad_addr_q = '0;
`endif

  assign bus.out_valid    = out_valid;
  assign bus.out_addr     = out_valid ? mem_q[rd_ptr_q].addr  : '0;
  assign bus.out_wdata    = out_valid ? mem_q[rd_ptr_q].wdata : '0;
  assign bus.out_be       = out_valid ? mem_q[rd_ptr_q].be    : '0;
  assign bus.count        = count_q;
  assign bus.misalign_err = err_q;
  assign bus.bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_store_lane_packer.sv
// Self-checking bench for store_lane_packer: directed cases plus random traffic vs a queue model.
module tb_store_lane_packer;

  localparam int unsigned Depth = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ref_entry_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ref_entry_t  q[$];
  logic        err_exp;
  logic [31:0] bad_exp;

  store_lane_packer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(Depth)) ifc ();

  store_lane_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(Depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ref_entry_t pack_ref(input logic [31:0] a, input logic [31:0] d,
                                          input logic [1:0] s);
    ref_entry_t  e;
    int unsigned off;
    off    = a % 4;
    e.addr = a - off;
    case (s)
      2'd0: begin
        e.wdata = d[7:0] * 32'h0101_0101;
        e.be    = 4'(1 << off);
      end
      2'd1: begin
        e.wdata = d[15:0] * 32'h0001_0001;
        e.be    = (off >= 2) ? 4'hC : 4'h3;
      end
      default: begin
        e.wdata = d;
        e.be    = 4'hF;
      end
    endcase
    return e;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd0) return 1'b0;
    if (s == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic check_outputs();
    check_eq("count", 64'(ifc.count), 64'(q.size()));
    check_eq("out_valid", 64'(ifc.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("out_addr", 64'(ifc.out_addr), 64'(q[0].addr));
      check_eq("out_wdata", 64'(ifc.out_wdata), 64'(q[0].wdata));
      check_eq("out_be", 64'(ifc.out_be), 64'(q[0].be));
    end
    check_eq("misalign_err", 64'(ifc.misalign_err), 64'(err_exp));
    check_eq("bad_addr", 64'(ifc.bad_addr), 64'(bad_exp));
  endtask

  // One clock: drive at negedge, check ready, update model at posedge, check at next negedge.
  task automatic step(input logic f, input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic ordy);
    bit mready, acc, pop, trap;
    ifc.flush     = f;
    ifc.in_valid  = v;
    ifc.in_addr   = a;
    ifc.in_data   = d;
    ifc.in_size   = s;
    ifc.out_ready = ordy;
    #1;
    mready = (q.size() < Depth) && !f;
    check_eq("in_ready", 64'(ifc.in_ready), 64'(mready));
    acc = v && mready;
    pop = (q.size() != 0) && ordy;
`ifdef MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    @(posedge clk);
    err_exp = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (trap && is_mis(a, s)) begin
          err_exp = 1'b1;
          bad_exp = a;
        end else begin
          q.push_back(pack_ref(a, d, s));
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    err_exp = 1'b0;
    bad_exp = '0;
    rst_n   = 1'b0;
    ifc.flush = 0; ifc.in_valid = 0; ifc.in_addr = 0; ifc.in_data = 0;
    ifc.in_size = 0; ifc.out_ready = 0;
    @(negedge clk);
    check_outputs();
    check_eq("rst_out_addr", 64'(ifc.out_addr), 64'h0);
    check_eq("rst_out_wdata", 64'(ifc.out_wdata), 64'h0);
    check_eq("rst_out_be", 64'(ifc.out_be), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // sb / sh / sw lane placement
    step(0, 1, 32'h1003, 32'hAABB_CC5A, 2'd0, 0);
    check_eq("t1_addr", 64'(ifc.out_addr), 64'h1000);
    check_eq("t1_wdata", 64'(ifc.out_wdata), 64'h5A5A_5A5A);
    check_eq("t1_be", 64'(ifc.out_be), 64'h8);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h2002, 32'h0000_1234, 2'd1, 0);
    check_eq("t2_wdata", 64'(ifc.out_wdata), 64'h1234_1234);
    check_eq("t2_be", 64'(ifc.out_be), 64'hC);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h3000, 32'hDEAD_BEEF, 2'd2, 0);
    check_eq("t2_sw_be", 64'(ifc.out_be), 64'hF);
    step(0, 0, 0, 0, 0, 1);

    // back-pressure: third push refused, then in-order drain
    for (int i = 0; i < 3; i++) step(0, 1, 32'h100 + 32'(4 * i), 32'(i + 1), 2'd2, 0);
    check_eq("t3_full_count", 64'(ifc.count), 64'd2);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // simultaneous push and pop at count 1
    step(0, 1, 32'h500, 32'h11, 2'd2, 0);
    step(0, 1, 32'h504, 32'h22, 2'd2, 1);
    check_eq("t4_count", 64'(ifc.count), 64'd1);
    check_eq("t4_next", 64'(ifc.out_addr), 64'h504);
    step(0, 1, 32'h508, 32'h33, 2'd2, 0);

    // flush with full buffer and a pending push
    step(1, 1, 32'h600, 32'h44, 2'd2, 0);
    check_eq("t5_count", 64'(ifc.count), 64'd0);

    // misaligned word store
    step(0, 1, 32'h4001, 32'h55, 2'd2, 0);
`ifdef MISALIGN_TRAP_EN
    check_eq("t6_err", 64'(ifc.misalign_err), 64'd1);
    check_eq("t6_bad", 64'(ifc.bad_addr), 64'h4001);
`else
    check_eq("t6_addr", 64'(ifc.out_addr), 64'h4000);
    check_eq("t6_be", 64'(ifc.out_be), 64'hF);
`endif
    step(0, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), $urandom(), $urandom(),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end

    // asynchronous reset drops entries without a clock edge
    step(0, 1, 32'h700, 32'h66, 2'd2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    err_exp = 1'b0;
    bad_exp = '0;
    check_eq("async_count", 64'(ifc.count), 64'd0);
    check_eq("async_valid", 64'(ifc.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 32'h800, 32'h77, 2'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
